// File: rtl/frame_double_buffer.sv
// Double-buffered 1-bit framebuffer: renderer writes the back bank, display reads the front bank,
// banks swap at vblank onset after a finished frame. Optional repeat counter: FRAME_REPEAT_CNT_EN.
module frame_double_buffer #(
  parameter int unsigned HOR_ACTIVE_PIXELS = 640,
  parameter int unsigned VER_ACTIVE_PIXELS = 480,
  localparam int unsigned ADDR_WIDTH = $clog2(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic                  wr_data,
  input  logic                  frame_ready,
  output logic                  swap,
  input  logic                  vblank,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_data,
  output logic                  rd_valid,
  output logic [15:0]           repeat_cnt
);

  localparam int unsigned NumPix = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS;
  localparam logic [ADDR_WIDTH:0] NumPixW = (ADDR_WIDTH + 1)'(NumPix);

  localparam logic [1:0] StWaitFrame  = 2'd0;
  localparam logic [1:0] StWaitVblank = 2'd1;
  localparam logic [1:0] StRelease    = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              front_sel_q, front_sel_d;
  logic              swap_q, swap_d;
  logic              rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              vblank_d_q;
  logic [NumPix-1:0] mem_q [2];
  logic [NumPix-1:0] mem_d [2];

  logic vblank_rise;
  logic do_swap;
  logic wr_in_range;
  logic rd_in_range;

  assign vblank_rise = vblank & ~vblank_d_q;
  assign wr_in_range = {1'b0, wr_addr} < NumPixW;
  assign rd_in_range = {1'b0, rd_addr} < NumPixW;

  always_comb begin
    state_d = state_q;
    do_swap = 1'b0;
    case (state_q)
      StWaitFrame: begin
        if (frame_ready) state_d = StWaitVblank;
      end
      StWaitVblank: begin
        // A frame withdrawn before the blank is dropped rather than shown.
        if (!frame_ready) begin
          state_d = StWaitFrame;
        end else if (vblank_rise) begin
          do_swap = 1'b1;
          state_d = StRelease;
        end
      end
      StRelease: begin
        if (!frame_ready) state_d = StWaitFrame;
      end
      default: state_d = StWaitFrame;
    endcase
  end

  always_comb begin
    front_sel_d = front_sel_q ^ do_swap;
    swap_d      = do_swap;
    rd_valid_d  = rd_en;
    rd_data_d   = rd_data_q;
    if (rd_en) rd_data_d = rd_in_range ? mem_q[front_sel_q][rd_addr] : 1'b0;
  end

  // Writes use the pre-toggle selector, so a write in the swap cycle lands in the new front bank.
  always_comb begin
    mem_d = mem_q;
    if (wr_en && wr_in_range) mem_d[~front_sel_q][wr_addr] = wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StWaitFrame;
      front_sel_q <= 1'b0;
      swap_q      <= 1'b0;
      rd_data_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      vblank_d_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      front_sel_q <= front_sel_d;
      swap_q      <= swap_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      vblank_d_q  <= vblank;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign swap     = swap_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

`ifdef FRAME_REPEAT_CNT_EN
  logic [15:0] repeat_cnt_q, repeat_cnt_d;

  always_comb begin
    repeat_cnt_d = repeat_cnt_q;
    if (vblank_rise && !do_swap && (repeat_cnt_q != 16'hFFFF)) begin
      repeat_cnt_d = repeat_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) repeat_cnt_q <= 16'h0000;
    else        repeat_cnt_q <= repeat_cnt_d;
  end

  assign repeat_cnt = repeat_cnt_q;
`else
  assign repeat_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_frame_double_buffer.sv
// Self-checking bench for frame_double_buffer: directed vector table plus randomized traffic
// checked against a frame-level reference model.
module tb_frame_double_buffer;

  localparam int H = 5;
  localparam int V = 3;
  localparam int NP = H * V;
  localparam int AW = 4;
`ifdef FRAME_REPEAT_CNT_EN
  localparam bit RepEn = 1'b1;
  localparam int SatBlanks = 65540;
`else
  localparam bit RepEn = 1'b0;
  localparam int SatBlanks = 300;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic          wr_data = 1'b0;
  logic          frame_ready = 1'b0;
  logic          swap;
  logic          vblank = 1'b0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_data;
  logic          rd_valid;
  logic [15:0]   repeat_cnt;

  frame_double_buffer #(
    .HOR_ACTIVE_PIXELS(H),
    .VER_ACTIVE_PIXELS(V)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_ready(frame_ready),
    .swap       (swap),
    .vblank     (vblank),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .repeat_cnt (repeat_cnt)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: frame bookkeeping as "finished frame pending" / "frame already shown".
  bit m_mem [2][NP];
  int m_front;
  bit m_swap, m_rd_data, m_rd_valid, m_prev_vb, m_armed, m_consumed;
  int m_rep;

  typedef struct {
    int fr, vb, we, wa, wd, re, ra;
    int e_swap, e_valid, e_rdata, e_rep;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(int fr, int vb, int we, int wa, int wd, int re, int ra,
                              int es, int ev, int ed, int er);
    vec_t v;
    v.fr = fr; v.vb = vb; v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra;
    v.e_swap = es; v.e_valid = ev; v.e_rdata = ed; v.e_rep = RepEn ? er : 0;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_front = 0; m_swap = 0; m_rd_data = 0; m_rd_valid = 0; m_rep = 0;
    m_prev_vb = 1; m_armed = 0; m_consumed = 0;
  endtask

  task automatic model_step();
    bit rise, sw;
    rise = vblank && !m_prev_vb;
    sw = 0;
    if (!frame_ready) begin
      m_armed = 0; m_consumed = 0;
    end else if (m_armed && rise) begin
      sw = 1; m_armed = 0; m_consumed = 1;
    end else if (!m_armed && !m_consumed) begin
      m_armed = 1;
    end
    if (rd_en) m_rd_data = (int'(rd_addr) < NP) ? m_mem[m_front][int'(rd_addr)] : 1'b0;
    m_rd_valid = rd_en;
    if (wr_en && int'(wr_addr) < NP) m_mem[1 - m_front][int'(wr_addr)] = wr_data;
    if (rise && !sw && m_rep < 65535) m_rep++;
    m_swap = sw;
    if (sw) m_front = 1 - m_front;
    m_prev_vb = vblank;
  endtask

  task automatic check_model();
    chk("swap", int'(swap), int'(m_swap));
    chk("rd_valid", int'(rd_valid), int'(m_rd_valid));
    chk("rd_data", int'(rd_data), int'(m_rd_data));
    chk("repeat_cnt", int'(repeat_cnt), RepEn ? m_rep : 0);
  endtask

  // One clock: inputs already driven; model advances at the edge, outputs sampled 1 later.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic set_in(int fr, int vb, int we, int wa, int wd, int re, int ra);
    frame_ready = fr[0]; vblank = vb[0]; wr_en = we[0]; wr_addr = AW'(wa);
    wr_data = wd[0]; rd_en = re[0]; rd_addr = AW'(ra);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk({tag, "_swap"}, int'(swap), 0);
    chk({tag, "_rd_valid"}, int'(rd_valid), 0);
    chk({tag, "_rd_data"}, int'(rd_data), 0);
    chk({tag, "_repeat"}, int'(repeat_cnt), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0]  = mk(1, 1, 1,  5, 1, 0,  0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 0,  0, 0, 1,  5, 0, 1, 0, 0);
    tbl[2]  = mk(1, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 1, 0,  0, 0, 1,  5, 1, 1, 0, 0);
    tbl[4]  = mk(1, 1, 0,  0, 0, 1,  5, 0, 1, 1, 0);
    tbl[5]  = mk(1, 0, 0,  0, 0, 0,  0, 0, 0, 1, 0);
    tbl[6]  = mk(1, 1, 0,  0, 0, 0,  0, 0, 0, 1, 1);
    tbl[7]  = mk(1, 0, 0,  0, 0, 0,  0, 0, 0, 1, 1);
    tbl[8]  = mk(1, 1, 0,  0, 0, 0,  0, 0, 0, 1, 2);
    tbl[9]  = mk(1, 1, 1, NP, 1, 1, NP, 0, 1, 0, 2);
    tbl[10] = mk(0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 2);
    tbl[11] = mk(1, 0, 0,  0, 0, 0,  0, 0, 0, 0, 2);
    tbl[12] = mk(1, 1, 1,  0, 1, 0,  0, 1, 0, 0, 2);
    tbl[13] = mk(1, 1, 0,  0, 0, 1,  0, 0, 1, 1, 2);
    tbl[14] = mk(0, 0, 0,  0, 0, 0,  0, 0, 0, 1, 2);
    tbl[15] = mk(1, 1, 0,  0, 0, 0,  0, 0, 0, 1, 3);
    tbl[16] = mk(1, 0, 0,  0, 0, 0,  0, 0, 0, 1, 3);
    tbl[17] = mk(1, 1, 0,  0, 0, 0,  0, 1, 0, 1, 3);

    // Clear both banks so every later read has a defined expectation.
    set_in(0, 0, 0, 0, 0, 0, 0);
    do_reset("rst0");
    for (int a = 0; a < NP; a++) begin
      set_in(0, 0, 1, a, 0, 0, 0);
      step();
    end
    set_in(1, 0, 0, 0, 0, 0, 0); step();
    set_in(1, 1, 0, 0, 0, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 0, 0); step();
    for (int a = 0; a < NP; a++) begin
      set_in(0, 0, 1, a, 0, 0, 0);
      step();
    end

    // Directed table, starting from a reset taken in the middle of a blank.
    set_in(1, 1, 0, 0, 0, 0, 0);
    do_reset("rst1");
    for (int i = 0; i < 18; i++) begin
      set_in(tbl[i].fr, tbl[i].vb, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].re, tbl[i].ra);
      step();
      chk($sformatf("tbl%0d_swap", i), int'(swap), tbl[i].e_swap);
      chk($sformatf("tbl%0d_rd_valid", i), int'(rd_valid), tbl[i].e_valid);
      chk($sformatf("tbl%0d_rd_data", i), int'(rd_data), tbl[i].e_rdata);
      chk($sformatf("tbl%0d_repeat", i), int'(repeat_cnt), tbl[i].e_rep);
    end

    // Reset lands while the swap pulse from the last table row is high.
    chk("pre_rst_swap", int'(swap), 1);
    do_reset("rst_mid");

    // Front bank must be bank 0 again after reset: pixel 0 of bank 0 was set to 1.
    set_in(0, 0, 0, 0, 0, 1, 0); step();
    chk("post_rst_front", int'(rd_data), 1);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      int fr, vb;
      fr = int'(frame_ready);
      vb = int'(vblank);
      if ($urandom_range(0, 19) == 0) fr = 1 - fr;
      if ($urandom_range(0, 5) == 0) vb = 1 - vb;
      set_in(fr, vb, int'($urandom_range(0, 1)), int'($urandom_range(0, NP)),
             int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), int'($urandom_range(0, NP)));
      step();
    end

    // Repeated blanks with no frame offered: counter saturates (or stays 0 when absent).
    set_in(0, 0, 0, 0, 0, 0, 0);
    do_reset("rst_sat");
    for (int b = 0; b < SatBlanks; b++) begin
      set_in(0, 0, 0, 0, 0, 0, 0); step();
      set_in(0, 1, 0, 0, 0, 0, 0); step();
    end
    chk("repeat_sat", int'(repeat_cnt), RepEn ? 65535 : 0);
    chk("sat_no_swap", int'(swap), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
